// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central stall/flush sequencer for a 5-stage IF/ID/EX/MEM/WB pipeline.
// It merges the following hazard sources into per-stage register enables,
// bubble inserts and PC redirect controls:
//   - load-use stall
//   - instruction-memory busy
//   - data-memory busy
//   - taken-branch resolution
// A two-state FSM (RUN / REDIRECT_PEND) holds a branch redirect that
// arrives while fetch is busy, so the redirect is never lost.
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall-cycle and
// redirect performance counters. When it is undefined, both counter ports
// read 0.

module pipeline_hazard_controller #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_use_stall,
  input  logic            branch_taken_ex,
  input  logic [XLEN-1:0] branch_target_ex,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  output logic            pc_en,
  output logic            pc_redirect,
  output logic [XLEN-1:0] pc_redirect_target,
  output logic            if_id_en,
  output logic            id_ex_en,
  output logic            ex_mem_en,
  output logic            mem_wb_en,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic            mem_wb_flush,
  output logic [31:0]     stall_cycles,
  output logic [31:0]     redirect_count
);

  typedef enum logic {
    RUN,
    REDIRECT_PEND
  } stateT;

  stateT           state_q, state_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;

  logic            pcEnRaw;
  logic            pcRedirectRaw;
  logic [XLEN-1:0] targetRaw;
  logic            ifIdEnRaw, idExEnRaw, exMemEnRaw, memWbEnRaw;
  logic            ifIdFlushRaw, idExFlushRaw, memWbFlushRaw;

  // State register and the pending redirect target captured while fetch is busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pend_target_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_target_q <= pend_target_d;
    end
  end

  // Hazard priority resolution: next state plus the raw (pre-reset-forcing) controls
  always_comb begin
    state_d       = state_q;
    pend_target_d = pend_target_q;
    pcEnRaw       = 1'b1;
    pcRedirectRaw = 1'b0;
    targetRaw     = branch_target_ex;
    ifIdEnRaw     = 1'b1;
    idExEnRaw     = 1'b1;
    exMemEnRaw    = 1'b1;
    memWbEnRaw    = 1'b1;
    ifIdFlushRaw  = 1'b0;
    idExFlushRaw  = 1'b0;
    memWbFlushRaw = 1'b0;
    case (state_q)
      RUN: begin
        if (dmem_busy) begin
          pcEnRaw       = 1'b0;
          ifIdEnRaw     = 1'b0;
          idExEnRaw     = 1'b0;
          exMemEnRaw    = 1'b0;
          memWbFlushRaw = 1'b1;
        end else if (branch_taken_ex) begin
          ifIdFlushRaw = 1'b1;
          idExFlushRaw = 1'b1;
          if (!imem_busy) begin
            pcRedirectRaw = 1'b1;
          end else begin
            pcEnRaw       = 1'b0;
            pend_target_d = branch_target_ex;
            state_d       = REDIRECT_PEND;
          end
        end else if (load_use_stall) begin
          pcEnRaw      = 1'b0;
          ifIdEnRaw    = 1'b0;
          idExFlushRaw = 1'b1;
        end else if (imem_busy) begin
          pcEnRaw      = 1'b0;
          ifIdFlushRaw = 1'b1;
        end
      end
      REDIRECT_PEND: begin
        ifIdFlushRaw = 1'b1;
        targetRaw    = pend_target_q;
        if (dmem_busy) begin
          pcEnRaw       = 1'b0;
          ifIdEnRaw     = 1'b0;
          idExEnRaw     = 1'b0;
          exMemEnRaw    = 1'b0;
          memWbFlushRaw = 1'b1;
        end else if (imem_busy) begin
          pcEnRaw = 1'b0;
        end else begin
          pcRedirectRaw = 1'b1;
          state_d       = RUN;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // While reset is low, hold every stage and fill the pipeline with bubbles
  always_comb begin
    pc_en              = rst_n & pcEnRaw;
    pc_redirect        = rst_n & pcRedirectRaw;
    pc_redirect_target = rst_n ? targetRaw : '0;
    if_id_en           = rst_n & ifIdEnRaw;
    id_ex_en           = rst_n & idExEnRaw;
    ex_mem_en          = rst_n & exMemEnRaw;
    mem_wb_en          = rst_n & memWbEnRaw;
    if_id_flush        = ~rst_n | ifIdFlushRaw;
    id_ex_flush        = ~rst_n | idExFlushRaw;
    mem_wb_flush       = ~rst_n | memWbFlushRaw;
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] redirect_count_q, redirect_count_d;

  // Next counter values; both counters wrap naturally at 2^32
  always_comb begin
    stall_cycles_d   = stall_cycles_q;
    redirect_count_d = redirect_count_q;
    if (!pc_en) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (pc_redirect) begin
      redirect_count_d = redirect_count_q + 32'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q   <= '0;
      redirect_count_q <= '0;
    end else begin
      stall_cycles_q   <= stall_cycles_d;
      redirect_count_q <= redirect_count_d;
    end
  end

  assign stall_cycles   = stall_cycles_q;
  assign redirect_count = redirect_count_q;
`else
  assign stall_cycles   = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb_pipeline_hazard_controller
// Scenario-driven bench for the hazard controller. Every cycle pushes its
// expected control vector into a scoreboard when the stimulus is driven, and
// the same vector is popped and compared once the outputs have settled.
// Control vector bit order, MSB first:
//   pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
//   if_id_flush, id_ex_flush, mem_wb_flush
// A per-row mask excludes bits that the hazard rules leave unconstrained.

module tb_pipeline_hazard_controller;

  localparam int XLEN = 32;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [8:0] ALL        = 9'b1_1_1_1_1_1_1_1_1;
  localparam logic [8:0] NORM       = 9'b1_0_1_1_1_1_0_0_0;
  localparam logic [8:0] FORCED     = 9'b0_0_0_0_0_0_1_1_1;
  localparam logic [8:0] LU_CTL     = 9'b0_0_0_0_1_1_0_1_0;
  localparam logic [8:0] LU_MSK     = 9'b1_1_1_0_1_1_1_1_1;
  localparam logic [8:0] IMEM_CTL   = 9'b0_0_0_1_1_1_1_0_0;
  localparam logic [8:0] IMEM_MSK   = 9'b1_1_0_1_1_1_1_1_1;
  localparam logic [8:0] BRR_CTL    = 9'b1_1_0_0_1_1_1_1_0;
  localparam logic [8:0] BRB_CTL    = 9'b0_0_0_0_1_1_1_1_0;
  localparam logic [8:0] BR_MSK     = 9'b1_1_0_0_1_1_1_1_1;
  localparam logic [8:0] PGO_CTL    = 9'b1_1_1_1_1_1_1_0_0;
  localparam logic [8:0] FRZ_CTL    = 9'b0_0_0_0_0_0_0_0_1;
  localparam logic [8:0] PFRZ_CTL   = 9'b0_0_0_0_0_0_1_0_1;
  localparam logic [8:0] FRZ_MSK    = 9'b1_1_1_1_1_0_1_1_1;

  typedef struct {
    string       name;
    logic        rstN;
    logic        lu;
    logic        br;
    logic        im;
    logic        dm;
    logic [31:0] tgtIn;
    logic [8:0]  ctl;
    logic [8:0]  mask;
    bit          chkTgt;
    logic [31:0] tgt;
  } rowT;

  typedef struct {
    string       name;
    logic [31:0] stalls;
    logic [31:0] redirects;
  } cntT;

  logic            clk;
  logic            rst_n;
  logic            load_use_stall;
  logic            branch_taken_ex;
  logic [XLEN-1:0] branch_target_ex;
  logic            imem_busy;
  logic            dmem_busy;
  logic            pc_en;
  logic            pc_redirect;
  logic [XLEN-1:0] pc_redirect_target;
  logic            if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic            if_id_flush, id_ex_flush, mem_wb_flush;
  logic [31:0]     stall_cycles;
  logic [31:0]     redirect_count;
  logic [8:0]      obsCtl;

  rowT sb[$];
  cntT cntSb[$];
  int  total = 0;
  int  bad   = 0;

  pipeline_hazard_controller #(.XLEN(XLEN)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .load_use_stall     (load_use_stall),
    .branch_taken_ex    (branch_taken_ex),
    .branch_target_ex   (branch_target_ex),
    .imem_busy          (imem_busy),
    .dmem_busy          (dmem_busy),
    .pc_en              (pc_en),
    .pc_redirect        (pc_redirect),
    .pc_redirect_target (pc_redirect_target),
    .if_id_en           (if_id_en),
    .id_ex_en           (id_ex_en),
    .ex_mem_en          (ex_mem_en),
    .mem_wb_en          (mem_wb_en),
    .if_id_flush        (if_id_flush),
    .id_ex_flush        (id_ex_flush),
    .mem_wb_flush       (mem_wb_flush),
    .stall_cycles       (stall_cycles),
    .redirect_count     (redirect_count)
  );

  assign obsCtl = {pc_en, pc_redirect, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                   if_id_flush, id_ex_flush, mem_wb_flush};

  // Free-running clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic rowT mkRow(input string name, input logic rstN, input logic lu,
                                input logic br, input logic im, input logic dm,
                                input logic [31:0] tgtIn, input logic [8:0] ctl,
                                input logic [8:0] mask, input bit chkTgt,
                                input logic [31:0] tgt);
    rowT r;
    r.name   = name;
    r.rstN   = rstN;
    r.lu     = lu;
    r.br     = br;
    r.im     = im;
    r.dm     = dm;
    r.tgtIn  = tgtIn;
    r.ctl    = ctl;
    r.mask   = mask;
    r.chkTgt = chkTgt;
    r.tgt    = tgt;
    return r;
  endfunction

  // Drive one cycle of inputs on the falling edge and record what should appear
  task automatic applyStimulus(input rowT r);
    @(negedge clk);
    rst_n            = r.rstN;
    load_use_stall   = r.lu;
    branch_taken_ex  = r.br;
    branch_target_ex = r.tgtIn;
    imem_busy        = r.im;
    dmem_busy        = r.dm;
    sb.push_back(r);
  endtask

  task automatic test_reset();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("reset_forced_busy", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0ABC, FORCED, ALL, 1'b1, 32'h0));
    rows.push_back(mkRow("reset_forced_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FORCED, ALL, 1'b1, 32'h0));
    rows.push_back(mkRow("first_run_cycle",   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_stalls();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("load_use",       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, LU_CTL, LU_MSK, 1'b0, 32'h0));
    rows.push_back(mkRow("after_load_use", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    rows.push_back(mkRow("imem_busy_run",  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IMEM_CTL, IMEM_MSK, 1'b0, 32'h0));
    rows.push_back(mkRow("lu_over_imem",   1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, LU_CTL, LU_MSK, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_branch_ready();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("branch_ready",      1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, BRR_CTL, BR_MSK, 1'b1, 32'h0000_0100));
    rows.push_back(mkRow("after_branch_run",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_branch_busy();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("branch_busy_c1",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0200, BRB_CTL, BR_MSK, 1'b1, 32'h0000_0200));
    rows.push_back(mkRow("pend_wait_c2",    1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_DEAD, IMEM_CTL, IMEM_MSK, 1'b1, 32'h0000_0200));
    rows.push_back(mkRow("pend_ignores_br", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0555, IMEM_CTL, IMEM_MSK, 1'b1, 32'h0000_0200));
    rows.push_back(mkRow("pend_release",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0777, PGO_CTL, ALL, 1'b1, 32'h0000_0200));
    rows.push_back(mkRow("back_in_run",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_priority();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("dmem_freeze_all",  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0300, FRZ_CTL, FRZ_MSK, 1'b0, 32'h0));
    rows.push_back(mkRow("branch_over_lu",   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, BRR_CTL, BR_MSK, 1'b1, 32'h0000_0300));
    rows.push_back(mkRow("priority_idle",    1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_back_to_back();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("b2b_enter_pend",  1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0400, BRB_CTL, BR_MSK, 1'b1, 32'h0000_0400));
    rows.push_back(mkRow("b2b_pend_freeze", 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, PFRZ_CTL, FRZ_MSK, 1'b1, 32'h0000_0400));
    rows.push_back(mkRow("b2b_pend_go",     1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, PGO_CTL, ALL, 1'b1, 32'h0000_0400));
    rows.push_back(mkRow("b2b_second_br",   1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, BRR_CTL, BR_MSK, 1'b1, 32'h0000_0500));
    rows.push_back(mkRow("b2b_idle",        1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_reset_pend();
    rowT rows[$];
    rowT e;
    rows.push_back(mkRow("rp_enter_pend",   1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0600, BRB_CTL, BR_MSK, 1'b1, 32'h0000_0600));
    rows.push_back(mkRow("rp_reset_forced", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0600, FORCED, ALL, 1'b1, 32'h0));
    rows.push_back(mkRow("rp_no_redirect",  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    foreach (rows[i]) begin
      applyStimulus(rows[i]);
      #1;
      e = sb.pop_front();
      total++;
      if ((((obsCtl ^ e.ctl) & e.mask) !== 9'd0) || (e.chkTgt && (pc_redirect_target !== e.tgt))) begin
        bad++;
        $display("[TB] FAIL %s: got ctl=%b tgt=%h, want ctl=%b (mask %b) tgt=%h",
                 e.name, obsCtl, pc_redirect_target, e.ctl, e.mask, e.tgt);
      end
    end
  endtask

  task automatic test_counters();
    rowT r;
    cntT c;
    applyStimulus(mkRow("cnt_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, FORCED, ALL, 1'b0, 32'h0));
    cntSb.push_back('{name: "cnt_in_reset", stalls: 32'd0, redirects: 32'd0});
    #1;
    r = sb.pop_front();
    c = cntSb.pop_front();
    total++;
    if ((stall_cycles !== c.stalls) || (redirect_count !== c.redirects)) begin
      bad++;
      $display("[TB] FAIL %s: got stalls=%0d redirects=%0d, want stalls=%0d redirects=%0d",
               c.name, stall_cycles, redirect_count, c.stalls, c.redirects);
    end
    applyStimulus(mkRow("cnt_release", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    for (int i = 0; i < 5; i++) begin
      applyStimulus(mkRow("cnt_stall", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, IMEM_CTL, IMEM_MSK, 1'b0, 32'h0));
    end
    for (int i = 0; i < 2; i++) begin
      applyStimulus(mkRow("cnt_redirect", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0800, BRR_CTL, BR_MSK, 1'b0, 32'h0));
    end
    applyStimulus(mkRow("cnt_idle", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, NORM, ALL, 1'b0, 32'h0));
    cntSb.push_back('{name: "cnt_after_traffic",
                      stalls: PERF ? 32'd5 : 32'd0,
                      redirects: PERF ? 32'd2 : 32'd0});
    #1;
    sb.delete();
    c = cntSb.pop_front();
    total++;
    if ((stall_cycles !== c.stalls) || (redirect_count !== c.redirects)) begin
      bad++;
      $display("[TB] FAIL %s: got stalls=%0d redirects=%0d, want stalls=%0d redirects=%0d",
               c.name, stall_cycles, redirect_count, c.stalls, c.redirects);
    end
  endtask

  // Run every scenario in order and report the totals
  initial begin
    rst_n            = 1'b0;
    load_use_stall   = 1'b0;
    branch_taken_ex  = 1'b0;
    branch_target_ex = '0;
    imem_busy        = 1'b0;
    dmem_busy        = 1'b0;
    test_reset();
    test_stalls();
    test_branch_ready();
    test_branch_busy();
    test_priority();
    test_back_to_back();
    test_reset_pend();
    test_counters();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
